alu_seq_mult: RTL and testbench
===============================

// Module: alu_seq_mult
// PURPOSE
//  Iterative unsigned shift-and-add multiplier for the 32-bit ALU datapath.
//  Consumes operand pairs via valid/ready and yields a 64-bit product.
//  product_lo drives the in1 leg of the ALU result mux32; sel comes from the op decode.
//  Trades latency for area: one add per clock, no array multiplier.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; iteration count bound
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      synchronous reset, active-low
//  in_valid    in   1      operands a/b valid
//  in_ready    out  1      block can accept operands
//  a           in   WIDTH  multiplicand
//  b           in   WIDTH  multiplier
//  out_valid   out  1      product valid
//  out_ready   in   1      consumer takes product
//  product_lo  out  WIDTH  product[WIDTH-1:0], to ALU result mux
//  product_hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
//  busy        out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge): state=IDLE, out_valid=0, product=0, counters=0.
//    in_ready=0 while rst_n is low. Reset mid-RUN or in DONE aborts and discards the op.
//  - FSM states: IDLE, RUN, DONE (mult_state_t).
//  - IDLE: in_ready=1. On the edge with in_valid&&in_ready: mcand<=zext(a) (2*WIDTH bits),
//    mplier<=b, acc<=0, count<=0, go RUN. in_valid && !in_ready is ignored (no capture).
//  - RUN, per edge: if mplier[0], acc<=acc+mcand (mod 2^(2*WIDTH), no overflow possible).
//    Then mcand<<=1, mplier>>=1, count<=count+1. Edge with count==WIDTH-1 -> DONE.
//  - Latency: out_valid rises exactly WIDTH cycles after the accept edge (32 by default).
//  - DONE: out_valid=1; {product_hi,product_lo}=acc. Outputs stay stable while !out_ready.
//    Edge with out_ready -> IDLE and out_valid=0. No accept in the same cycle;
//    earliest next accept is the following cycle.
//  - in_ready=0 and busy=1 in RUN and DONE. product_* hold the last result in IDLE.
//  - Arithmetic is unsigned only. Width of count is $clog2(WIDTH)+1.
// CONFIGURATION
//  ALU_MULT_EARLY_TERM_EN
//   defined: in RUN, go DONE on the edge where the shifted mplier becomes 0,
//     or where count==WIDTH-1, whichever is first.
//     Latency is max(1, msb_index(b)+1) cycles: b=0 -> 1, b=5 -> 3.
//     Product values are identical to the non-early-termination build.
//   undefined: fixed WIDTH-cycle latency independent of operands.
// STRUCTURE
//  alu_pkg: MULT_WIDTH=32 default constant; typedef enum logic [1:0]
//   {IDLE,RUN,DONE} mult_state_t.
//  Sub-module mult_step (combinational): {acc,mcand,mplier} -> next values, one iteration.
//  The top holds the FSM, count and handshake.
// TESTING
//  1 a=3,b=5, out_ready=1 -> product=15 (hi=0), out_valid exactly 32 cycles after accept.
//  2 a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  3 a=0x12345678, b=0x9ABCDEF0, out_ready held 0 for 10 cycles -> out_valid and product
//    stable throughout; handshake then IDLE, in_ready=1 the next cycle.
//  4 Accept, pulse rst_n low at RUN cycle 10 -> out_valid stays 0; in_ready=1 the cycle
//    after release. A new op a=7,b=6 -> 42.
//  5 in_valid held high with changing a/b during RUN -> ignored; the result matches the
//    captured pair.
//  6 ALU_MULT_EARLY_TERM_EN: b=0 -> latency 1, product 0; a=9,b=5 -> latency 3,
//    product 45; b=0x80000000 -> latency 32.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequential multiplier.
package alu_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditional accumulate, then shift the operands.
module mult_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // Add the multiplicand when the current multiplier LSB is set; the
    // 2*WIDTH accumulator can never overflow for WIDTH x WIDTH operands.
    always_comb begin
        acc_next    = acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

endmodule

// File: rtl/alu_seq_mult.sv
// Iterative unsigned shift-and-add multiplier with valid/ready handshakes.
// Optional build macro: ALU_MULT_EARLY_TERM_EN (stop as soon as the
// remaining multiplier bits are all zero).
module alu_seq_mult
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    mult_state_t    state;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]  count;
    logic [PW-1:0]  product;

    logic [PW-1:0]  acc_nx;
    logic [PW-1:0]  mcand_nx;
    logic [WIDTH-1:0] mplier_nx;
    logic           last_iter;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_nx),
        .mcand_next  (mcand_nx),
        .mplier_next (mplier_nx)
    );

    // Decide whether the current RUN iteration is the final one.
    always_comb begin
        last_iter = (count == CW'(WIDTH - 1));
`ifdef ALU_MULT_EARLY_TERM_EN
        if (mplier_nx == '0) begin
            last_iter = 1'b1;
        end
`endif
    end

    // Handshake status decoded from state; held off while reset is asserted.
    assign in_ready   = rst_n && (state == IDLE);
    assign busy       = (state == RUN) || (state == DONE);
    assign product_lo = product[WIDTH-1:0];
    assign product_hi = product[PW-1:WIDTH];

    // Control FSM, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= PW'(a);
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nx;
                    mcand  <= mcand_nx;
                    mplier <= mplier_nx;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        product   <= acc_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_mult.sv
// Self-checking bench for alu_seq_mult: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_alu_seq_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product_lo;
    logic [31:0] product_hi;
    logic        busy;

    int checks;
    int errors;

    alu_seq_mult dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product_lo (product_lo),
        .product_hi (product_hi),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cycles from accept to out_valid.
    function automatic int exp_lat(input logic [31:0] bv);
`ifdef ALU_MULT_EARLY_TERM_EN
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) begin
            if (bv[i]) m = i + 1;
        end
        return (m == 0) ? 1 : m;
`else
        return (bv === 32'hx) ? 0 : 32;
`endif
    endfunction

    // Issue one operation, check latency/product, stall, then hand off.
    task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i,
                         input int hold, input bit noisy, input string tag);
        logic [63:0] exp_p;
        int n;
        int lat;
        exp_p = 64'(a_i) * 64'(b_i);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a = a_i; b = b_i; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        if (!noisy) in_valid = 1'b0;
        chk({tag, "_busy_run"}, {62'd0, busy, in_ready}, 64'b10);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (noisy) begin a = $urandom; b = $urandom; end
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(b_i)));
        chk({tag, "_product"}, {product_hi, product_lo}, exp_p);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_product"}, {product_hi, product_lo}, exp_p);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_after_hs"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk({tag, "_idle_product"}, {product_hi, product_lo}, exp_p);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {60'd0, out_valid, in_ready, busy, 1'b0}, 64'd0);
        chk("reset_product", {product_hi, product_lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        do_op(32'd3, 32'd5, 0, 1'b0, "t1_small");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "t2_max");
        chk("t2_hi", 64'(product_hi), 64'hFFFF_FFFE);
        chk("t2_lo", 64'(product_lo), 64'h0000_0001);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0, "t3_stall");

        // Reset mid-RUN discards the op.
        a = 32'd11; b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t4_rst_valid", {62'd0, out_valid, in_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t4_release", {62'd0, in_ready, busy}, 64'b10);
        chk("t4_product_cleared", {product_hi, product_lo}, 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) break;
        end
        chk("t4_no_valid", 64'(out_valid), 64'd0);
        do_op(32'd7, 32'd6, 0, 1'b0, "t4_new");

        // Noisy in_valid during RUN.
        do_op(32'hDEAD_BEEF, 32'h0000_1234, 2, 1'b1, "t5_noisy");

        // Operands that exercise the early-termination latency rules.
        do_op(32'h1357_9BDF, 32'd0, 0, 1'b0, "t6_b0");
        do_op(32'd9, 32'd5, 0, 1'b0, "t6_b5");
        do_op(32'hCAFE_F00D, 32'h8000_0000, 0, 1'b0, "t6_bmsb");

        // Random operands, some with narrowed multipliers.
        for (int k = 0; k < 10; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (k % 2 == 1) rb = rb >> $urandom_range(31, 1);
            do_op(ra, rb, int'($urandom_range(3, 0)), bit'(k % 3 == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
